// File: rtl/golden_nonce_uart_tx.sv
// Golden nonce return path: small nonce FIFO feeding a UART 8N1 serialiser.
// Each 32-bit nonce leaves as 4 bytes, least significant byte first.
module golden_nonce_uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_LOG2    = 2
) (
  input  logic                 hash_clk,
  input  logic                 reset_n,
  input  logic                 nonce_valid,
  input  logic [31:0]          nonce_in,
  output logic                 uart_txd,
  output logic                 busy,
  output logic [FIFO_LOG2:0]   fifo_level,
  output logic                 overflow
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          mem_q [DEPTH];
  logic [31:0]          mem_d [DEPTH];
  logic [FIFO_LOG2:0]   wr_q, wr_d;
  logic [FIFO_LOG2:0]   rd_q, rd_d;
  logic [31:0]          shift_q, shift_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [1:0]           byte_q, byte_d;
  logic                 txd_q, txd_d;
  logic                 ovf_q, ovf_d;

  logic empty;
  logic full;
  logic pop;
  logic push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[FIFO_LOG2] != rd_q[FIFO_LOG2]) &&
                 (wr_q[FIFO_LOG2-1:0] == rd_q[FIFO_LOG2-1:0]);
  assign pop   = (state_q == IDLE) && !empty;
  // A full FIFO still takes a word when the head leaves on the same edge
  assign push  = nonce_valid && (!full || pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    ovf_d = ovf_q;
    if (push) begin
      mem_d[wr_q[FIFO_LOG2-1:0]] = nonce_in;
      wr_d = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    if (nonce_valid && !push) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    txd_d   = txd_q;
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          shift_d = mem_q[rd_q[FIFO_LOG2-1:0]];
          byte_d  = 2'd0;
          baud_d  = '0;
          state_d = START;
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
          txd_d  = 1'b0;
        end
      end
      DATA: begin
        if (baud_q == BAUD_MAX) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[31:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
          txd_d  = shift_q[0];
        end
      end
      STOP: begin
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (byte_q == 2'd3) begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = START;
            txd_d   = 1'b0;
          end
        end else begin
          baud_d = baud_q + BW'(1);
          txd_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge hash_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign uart_txd   = txd_q;
  assign busy       = (state_q != IDLE) || !empty;
  assign fifo_level = wr_q - rd_q;
  assign overflow   = ovf_q;

endmodule
